// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory.
// The CPU owns memory by default; DMA gets idle slots, or is forced in after a bounded wait.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    // state   | meaning
    // CPU_OWN | CPU drives memory; DMA waits for an idle slot or the wait limit
    // DMA_OWN | DMA drives memory; CPU requests are stalled
    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_LAST  = 4'(MAX_WAIT - 1);
    localparam logic [3:0] WAIT_SAT   = 4'(MAX_WAIT);
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       dma_beat;

    assign dma_beat = (state_q == DMA_OWN) && dma_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CPU_OWN;
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            CPU_OWN: begin
                if (dma_req && !cpu_req) begin
                    state_d    = DMA_OWN;
                    wait_cnt_d = '0;
                    beat_cnt_d = '0;
                end else if (dma_req && cpu_req) begin
                    // the CPU access in this cycle still completes; DMA takes the next one
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = DMA_OWN;
                        wait_cnt_d = '0;
                        beat_cnt_d = '0;
                    end else if (wait_cnt_q != WAIT_SAT) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            DMA_OWN: begin
                if (dma_beat) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
                // the burst cap overrides dma_lock so the CPU is never starved for long
                if (!dma_req || (cpu_req && !dma_lock) ||
                    (dma_beat && beat_cnt_q == BURST_LAST)) begin
                    state_d    = CPU_OWN;
                    wait_cnt_d = '0;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d    = CPU_OWN;
                wait_cnt_d = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        mem_ce     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_stall  = 1'b0;
        dma_gnt    = 1'b0;
        dma_rvalid = 1'b0;
        owner      = 1'b0;
        // outputs stay quiet for the whole time reset is held, not just after the flops clear
        if (rst) begin
            if (state_q == DMA_OWN) begin
                mem_ce     = dma_req;
                mem_we     = dma_req && dma_we;
                mem_addr   = dma_addr;
                mem_wdata  = dma_wdata;
                cpu_stall  = cpu_req;
                dma_gnt    = dma_req;
                dma_rvalid = dma_req && !dma_we;
                owner      = 1'b1;
            end else begin
                mem_ce     = cpu_req;
                mem_we     = cpu_req && cpu_we;
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
            end
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and an expectation queue.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dma_req, dma_we, dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          dma_gnt, dma_rvalid;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          owner;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4), .BURST_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    logic [DW-1:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_ce && mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    typedef struct {
        string         tag;
        logic [DW-1:0] val;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic push(input string tag, input logic [DW-1:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [DW-1:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // advance to the next cycle's drive point; inputs are changed right after this
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    // counts consecutive dma_gnt cycles starting from the current cycle, bounded
    task automatic count_burst(output int n, output logic timed_out);
        n = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (dma_gnt) begin
                n++;
            end else if (n > 0) begin
                timed_out = 1'b0;
                break;
            end
            next_cycle();
            settle();
        end
    endtask

    int   n_gnt;
    int   n_wait;
    logic tmo;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = 32'h200; dma_wdata = 32'h0;

        // reset held with both requesting
        next_cycle(); next_cycle(); settle();
        push("rst_mem_ce", 0);    chk(32'(mem_ce));
        push("rst_cpu_stall", 0); chk(32'(cpu_stall));
        push("rst_dma_gnt", 0);   chk(32'(dma_gnt));
        push("rst_owner", 0);     chk(32'(owner));
        push("rst_mem_addr", 0);  chk(mem_addr);

        // release: starvation sequence, cycles 0..3 CPU served, cycle 4 DMA forced
        next_cycle(); rst = 1'b1; settle();
        push("rel_mem_ce", 1);        chk(32'(mem_ce));
        push("rel_mem_addr", 32'h100); chk(mem_addr);
        for (int c = 1; c < 4; c++) begin
            next_cycle(); settle();
            push("starve_cpu_owner", 0); chk(32'(owner));
            push("starve_cpu_stall", 0); chk(32'(cpu_stall));
        end
        next_cycle(); settle();
        push("starve_owner", 1); chk(32'(owner));
        push("starve_stall", 1); chk(32'(cpu_stall));
        push("starve_gnt", 1);   chk(32'(dma_gnt));
        next_cycle(); dma_req = 1'b0; settle();
        push("starve_return", 0); chk(32'(owner));

        // idle-slot DMA write of 0xDEADBEEF to 0x40
        next_cycle();
        cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hDEADBEEF;
        settle();
        push("idle_arb_owner", 0); chk(32'(owner));
        push("idle_arb_gnt", 0);   chk(32'(dma_gnt));
        next_cycle(); settle();
        push("idle_owner", 1);    chk(32'(owner));
        push("idle_gnt", 1);      chk(32'(dma_gnt));
        push("idle_mem_we", 1);   chk(32'(mem_we));
        push("idle_mem_addr", 32'h40); chk(mem_addr);
        push("idle_rvalid_wr", 0); chk(32'(dma_rvalid));
        next_cycle(); dma_req = 1'b0; dma_we = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        settle();
        push("idle_cpu_stalled", 1); chk(32'(cpu_stall));
        next_cycle(); settle();
        push("cpu_rd_stall", 0);        chk(32'(cpu_stall));
        push("cpu_rd_data", 32'hDEADBEEF); chk(cpu_rdata);

        // DMA read fan-out
        next_cycle(); cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; settle();
        next_cycle(); settle();
        push("rd_gnt", 1);              chk(32'(dma_gnt));
        push("rd_rvalid", 1);           chk(32'(dma_rvalid));
        push("rd_data", 32'hDEADBEEF);  chk(dma_rdata);
        next_cycle(); dma_req = 1'b0; settle();
        push("rd_drop_gnt", 0); chk(32'(dma_gnt));
        next_cycle(); settle();
        push("rd_drop_owner", 0); chk(32'(owner));

        // locked burst against a continuously requesting CPU
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h100; dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1;
        dma_addr = 32'h80; dma_wdata = 32'h1234;
        settle();
        n_wait = 0;
        while (!dma_gnt && n_wait < 10) begin
            n_wait++;
            next_cycle(); settle();
        end
        push("burst_wait_cycles", 4); chk(32'(n_wait));
        count_burst(n_gnt, tmo);
        push("burst_timeout", 0); chk(32'(tmo));
        push("burst_beats", 8);   chk(32'(n_gnt));
        push("burst_cap_owner", 0); chk(32'(owner));
        push("burst_cap_unstall", 0); chk(32'(cpu_stall));
        next_cycle(); dma_req = 1'b0; dma_lock = 1'b0; settle();

        // reset in the middle of a locked burst
        next_cycle(); cpu_req = 1'b0; dma_req = 1'b1; dma_lock = 1'b1; settle();
        for (int b = 0; b < 3; b++) begin
            next_cycle(); settle();
        end
        next_cycle(); rst = 1'b0; settle();
        push("midrst_owner", 0);  chk(32'(owner));
        push("midrst_gnt", 0);    chk(32'(dma_gnt));
        push("midrst_mem_ce", 0); chk(32'(mem_ce));
        next_cycle(); rst = 1'b1; settle();
        push("post_rst_owner", 0); chk(32'(owner));
        next_cycle(); cpu_req = 1'b1; settle();
        push("post_rst_entry", 1); chk(32'(owner));
        count_burst(n_gnt, tmo);
        push("post_rst_timeout", 0); chk(32'(tmo));
        push("post_rst_beats", 8);   chk(32'(n_gnt));

        next_cycle(); dma_req = 1'b0; dma_lock = 1'b0; cpu_req = 1'b0;
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
